// File: rtl/mem_unit.sv
// 32-word data memory with req/ack handshake and WAIT_CYCLES wait states per access.
// Optional per-word even parity with error reporting when MEM_PARITY_EN is defined.
module mem_unit #(
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        addr,
  input  logic              req,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              perr_inject,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ack,
  output logic              perr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [4:0]        addr_l_q, addr_l_d;
  logic              wr_l_q, wr_l_d;
  logic [DATA_W-1:0] wdata_l_q, wdata_l_d;
  logic              pinj_l_q, pinj_l_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              perr_q, perr_d;

  logic [DATA_W-1:0] mem_q [32];

  // Fields of the access that commits on this edge; from the inputs when
  // IDLE goes straight to DONE (WAIT_CYCLES = 0), otherwise from the latches.
  logic [4:0]        acc_addr;
  logic              acc_wr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_pinj;
  logic              commit;
  logic              mem_we;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_l_d  = addr_l_q;
    wr_l_d    = wr_l_q;
    wdata_l_d = wdata_l_q;
    pinj_l_d  = pinj_l_q;
    acc_addr  = addr_l_q;
    acc_wr    = wr_l_q;
    acc_wdata = wdata_l_q;
    acc_pinj  = pinj_l_q;
    commit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_l_d  = addr;
          wr_l_d    = wr;
          wdata_l_d = wdata;
          pinj_l_d  = perr_inject;
          acc_addr  = addr;
          acc_wr    = wr;
          acc_wdata = wdata;
          acc_pinj  = perr_inject;
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
            commit  = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_we  = commit & acc_wr;
    busy_d  = (state_d != S_IDLE);
    ack_d   = commit;
    rdata_d = (commit && !acc_wr) ? mem_q[acc_addr] : rdata_q;
  end

`ifdef MEM_PARITY_EN
  logic par_q [32];

  always_comb begin
    perr_d = commit && !acc_wr && (par_q[acc_addr] != ^mem_q[acc_addr]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) par_q[i] <= 1'b0;
    end else if (mem_we) begin
      par_q[acc_addr] <= (^acc_wdata) ^ acc_pinj;
    end
  end
`else
  logic unused_pinj;
  assign unused_pinj = acc_pinj;
  assign perr_d      = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_l_q  <= '0;
      wr_l_q    <= 1'b0;
      wdata_l_q <= '0;
      pinj_l_q  <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_l_q  <= addr_l_d;
      wr_l_q    <= wr_l_d;
      wdata_l_q <= wdata_l_d;
      pinj_l_q  <= pinj_l_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      perr_q    <= perr_d;
    end
  end

  // NOTE: the array is built from flops rather than a RAM macro because reset
  // must clear every word; a RAM-inferred block could not be reset this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[acc_addr] <= acc_wdata;
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign ack   = ack_q;
  assign perr  = perr_q;

endmodule

// File: tb/tb_mem_unit.sv
// Directed self-checking bench for mem_unit: one instance with WAIT_CYCLES=2 and
// one with WAIT_CYCLES=0; parity cases are compiled in only with MEM_PARITY_EN.
module tb_mem_unit;

  logic       clk;
  logic       rst;
  logic [4:0] addr,  addr0;
  logic       req,   req0;
  logic       wr,    wr0;
  logic [7:0] wdata, wdata0;
  logic       pinj,  pinj0;
  logic [7:0] rdata, rdata0;
  logic       busy,  busy0;
  logic       ack,   ack0;
  logic       perr,  perr0;

  int n_checks = 0;
  int n_errors = 0;

  mem_unit #(.DATA_W(8), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .req(req), .wr(wr), .wdata(wdata),
    .perr_inject(pinj), .rdata(rdata), .busy(busy), .ack(ack), .perr(perr)
  );

  mem_unit #(.DATA_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr0), .req(req0), .wr(wr0), .wdata(wdata0),
    .perr_inject(pinj0), .rdata(rdata0), .busy(busy0), .ack(ack0), .perr(perr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance: req for one cycle, then expect
  // ack three cycles after the request cycle with the given rdata/perr.
  task automatic access(input string tag, input logic w, input logic [4:0] a,
                        input logic [7:0] d, input logic inj,
                        input logic [7:0] exp_rd, input logic exp_perr);
    int n;
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wdata = d; pinj = inj;
    @(negedge clk);
    req = 1'b0; pinj = 1'b0;
    n = 1;
    while (!ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd3);
    check({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
    check({tag, " perr"}, 32'(perr), 32'(exp_perr));
  endtask

  initial begin
    int acks;
    rst = 1'b1;
    req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; pinj = 1'b0;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0; pinj0 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset rdata", 32'(rdata), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset ack", 32'(ack), 32'h0);
    check("reset perr", 32'(perr), 32'h0);
    rst = 1'b0;

    // 1: read addr 5, check busy/ack cycle by cycle
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 5'd5;
    check("t1 busy N", 32'(busy), 32'h0);
    @(negedge clk);
    req = 1'b0;
    check("t1 busy N+1", 32'(busy), 32'h1);
    check("t1 ack N+1", 32'(ack), 32'h0);
    @(negedge clk);
    check("t1 busy N+2", 32'(busy), 32'h1);
    check("t1 ack N+2", 32'(ack), 32'h0);
    @(negedge clk);
    check("t1 busy N+3", 32'(busy), 32'h1);
    check("t1 ack N+3", 32'(ack), 32'h1);
    check("t1 rdata", 32'(rdata), 32'h00);
    @(negedge clk);
    check("t1 busy N+4", 32'(busy), 32'h0);
    check("t1 ack N+4", 32'(ack), 32'h0);

    // 2: write then read back the top address
    access("t2 wr31", 1'b1, 5'd31, 8'hA5, 1'b0, 8'h00, 1'b0);
    access("t2 rd31", 1'b0, 5'd31, 8'h00, 1'b0, 8'hA5, 1'b0);

    // 3: zero-wait instance, req held high across two accesses
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b1; addr0 = 5'd0; wdata0 = 8'h3C;
    @(negedge clk);
    check("t3 ack N+1", 32'(ack0), 32'h1);
    check("t3 busy N+1", 32'(busy0), 32'h1);
    check("t3 wr rdata", 32'(rdata0), 32'h00);
    wr0 = 1'b0;
    @(negedge clk);
    check("t3 ack N+2", 32'(ack0), 32'h0);
    check("t3 busy N+2", 32'(busy0), 32'h0);
    @(negedge clk);
    req0 = 1'b0;
    check("t3 ack N+3", 32'(ack0), 32'h1);
    check("t3 rdata", 32'(rdata0), 32'h3C);

    // 4: address and req changes while busy are ignored
    access("t4 wr2", 1'b1, 5'd2, 8'h11, 1'b0, 8'hA5, 1'b0);
    access("t4 wr3", 1'b1, 5'd3, 8'h22, 1'b0, 8'hA5, 1'b0);
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 5'd2;
    @(negedge clk);
    req = 1'b0; addr = 5'd3;
    acks = int'(ack);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; wdata = 8'hFF;
    acks += int'(ack);
    @(negedge clk);
    req = 1'b0; wr = 1'b0;
    acks += int'(ack);
    check("t4 rdata", 32'(rdata), 32'h11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acks += int'(ack);
    end
    check("t4 ack count", 32'(acks), 32'd1);
    access("t4 rd3", 1'b0, 5'd3, 8'h00, 1'b0, 8'h22, 1'b0);

    // 5: reset during a pending write aborts it and clears memory
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 5'd9; wdata = 8'h77;
    @(negedge clk);
    req = 1'b0; wr = 1'b0;
    check("t5 busy pre", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t5 rst busy", 32'(busy), 32'h0);
    check("t5 rst ack", 32'(ack), 32'h0);
    check("t5 rst rdata", 32'(rdata), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    access("t5 rd9", 1'b0, 5'd9, 8'h00, 1'b0, 8'h00, 1'b0);
    access("t5 rd3", 1'b0, 5'd3, 8'h00, 1'b0, 8'h00, 1'b0);

`ifdef MEM_PARITY_EN
    // 6: injected parity error is flagged on read; clean word is not
    access("t6 wr4", 1'b1, 5'd4, 8'h0F, 1'b1, 8'h00, 1'b0);
    access("t6 rd4", 1'b0, 5'd4, 8'h00, 1'b0, 8'h0F, 1'b1);
    @(negedge clk);
    check("t6 perr after", 32'(perr), 32'h0);
    access("t6 wr6", 1'b1, 5'd6, 8'h0E, 1'b0, 8'h0F, 1'b0);
    access("t6 rd6", 1'b0, 5'd6, 8'h00, 1'b0, 8'h0E, 1'b0);
`else
    // injected parity is ignored without the feature
    access("t6 wr4", 1'b1, 5'd4, 8'h0F, 1'b1, 8'h00, 1'b0);
    access("t6 rd4", 1'b0, 5'd4, 8'h00, 1'b0, 8'h0F, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_unit.md
Name: mem_unit

Overview:
- 32-word data memory sitting directly downstream of the 5-bit memory address register; the MAR output drives `addr`.
- Executes one read or write per request through a req/ack handshake, with a parameterised number of wait states so the sequencer can be exercised against slow memory.
- Read data is held on `rdata` for the datapath to consume until the next read completes.

Parameters:
- DATA_W, 8, width of each memory word and of the data ports.
- WAIT_CYCLES, 2, wait states inserted per access; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- addr  input  5  word address, driven by the MAR output
- req  input  1  access request; sampled only in IDLE
- wr  input  1  access type, sampled with req: 1 = write, 0 = read
- wdata  input  DATA_W  write data, sampled with req
- perr_inject  input  1  test hook: corrupt stored parity on this write (used only with the optional feature)
- rdata  output  DATA_W  data of the last completed read
- busy  output  1  access in progress (state != IDLE)
- ack  output  1  one-cycle completion pulse
- perr  output  1  parity error on the completing read (used only with the optional feature)

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; rdata = 0, busy = 0, ack = 0, perr = 0.
  - Wait counter = 0; latched request fields = 0.
  - All 32 memory words (and parity bits, if present) = 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If req = 1 at a rising edge, latch addr, wr, wdata and perr_inject.
  - WAIT_CYCLES = 0: go to DONE. Otherwise load counter = WAIT_CYCLES and go to WAIT.
  - If req = 0, stay in IDLE.
- WAIT:
  - At each edge: if counter == 1, go to DONE; else decrement the counter.
- DONE:
  - ack = 1 and busy = 1 for exactly this cycle.
  - Unconditional return to IDLE on the next edge.
- Memory effect:
  - Happens on the edge that enters DONE, using the latched fields only.
  - Write: mem[addr_latched] = wdata_latched; rdata unchanged.
  - Read: rdata = mem[addr_latched]. rdata then holds until the next completed read or a reset.
- Latency: req sampled in cycle N gives ack in cycle N+1+WAIT_CYCLES.
- Throughput: the next req is accepted no earlier than the cycle after ack, i.e. one access per WAIT_CYCLES+2 cycles.
- busy = 1 in WAIT and DONE; ack and busy are registered outputs.
- req, addr, wr and wdata are ignored while busy. Changes on addr (for example a MAR reload) after acceptance do not affect the in-flight access.
- Read and write to the same address in consecutive accesses: the read returns the newly written value.
- Address wrap: none needed; all 32 addresses are valid and 5 bits fully decode.
- Reset mid-access: the access is aborted. A pending write is not committed, the FSM returns to IDLE, ack is not emitted, and memory is cleared.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit.
  - On write commit: parity = XOR of wdata_latched, inverted if perr_inject was latched as 1.
  - On read commit: perr = 1 during the DONE cycle when the stored parity differs from the recomputed parity of the stored word; otherwise 0.
  - perr is 0 outside DONE and on write completions; rdata is still returned.
- Not defined:
  - No parity storage.
  - perr is tied to 0 and perr_inject is ignored; ports remain present.

Test Plan:
1. Reset, then read addr 5 with WAIT_CYCLES=2 and req at cycle N -> busy=1 in cycles N+1..N+3; ack=1 only in N+3; rdata=0x00.
2. Write 0xA5 to addr 31, then read addr 31 -> the read ack cycle shows rdata=0xA5; the write ack leaves the prior rdata unchanged.
3. With WAIT_CYCLES=0, back-to-back requests with req held high, write 0x3C to addr 0 then read addr 0 -> acks at N+1 and N+3; rdata=0x3C.
4. Accept a read of addr 2 (holding 0x11), then change addr to 3 (holding 0x22) and pulse req while busy -> rdata=0x11; only one ack.
5. Write 0x77 to addr 9 and assert rst during WAIT -> outputs go to 0 immediately; a later read of addr 9 returns 0x00.
6. With MEM_PARITY_EN: write 0x0F to addr 4 with perr_inject=1, then read addr 4 -> perr=1 and rdata=0x0F on ack. A clean write then read -> perr=0.
